// File: rtl/cycle_pkg.sv
// Shared types and defaults for the button/sensor event decoder.
package cycle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG,
    LOCKED
  } btn_state_t;

  localparam int LONG_CYCLES_DEF   = 32768;
  localparam int REPEAT_CYCLES_DEF = 8192;
  localparam int CNT_W             = 16;

  typedef logic [CNT_W-1:0] hold_cnt_t;

  // Combo status that the top broadcasts to both button FSMs.
  typedef struct packed {
    logic active;    // both buttons low and both FSMs holding
    logic lock;      // combo completes this cycle
    logic bothHigh;  // both buttons released
  } combo_ctrl_t;

  function automatic hold_cnt_t satInc(hold_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic isHolding(btn_state_t s);
    return (s == HELD) || (s == LONG);
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Level inputs and event strobes of the button/sensor event decoder.
interface button_event_decoder_if;

  logic nTrip_deglitch;
  logic nMode_deglitch;
  logic nCrank_deglitch;
  logic nFork_deglitch;

  logic tripShort;
  logic tripLong;
  logic modeShort;
  logic modeLong;
  logic bothLong;
  logic crankPulse;
  logic forkPulse;

  modport master (
    output nTrip_deglitch, nMode_deglitch, nCrank_deglitch, nFork_deglitch,
    input  tripShort, tripLong, modeShort, modeLong, bothLong, crankPulse, forkPulse
  );

  modport slave (
    input  nTrip_deglitch, nMode_deglitch, nCrank_deglitch, nFork_deglitch,
    output tripShort, tripLong, modeShort, modeLong, bothLong, crankPulse, forkPulse
  );

endinterface

// File: rtl/button_fsm.sv
// Per-button short/long press FSM with combo lock-out.
// Optional macro AUTO_REPEAT_EN: repeated Short strobes while a long press is held.
module button_fsm
  import cycle_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        nRst,
  input  logic        level,
  input  logic        fall,
  input  combo_ctrl_t combo,
  output logic        shortPulse,
  output logic        longPulse,
  output btn_state_t  state
);

  if (LONG_CYCLES < 2 || LONG_CYCLES > 65536 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65536)
  begin : gBadCycles
    $error("button_fsm: LONG_CYCLES must be 2..65536 and REPEAT_CYCLES 1..65536");
  end

  // The press edge is hold cycle 1, so the counter reaching LONG_CYCLES-1 is hold cycle LONG_CYCLES.
  localparam hold_cnt_t LONG_TERM = hold_cnt_t'(LONG_CYCLES - 2);
  localparam hold_cnt_t LONG_LAST = hold_cnt_t'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam hold_cnt_t REPEAT_TERM = hold_cnt_t'(REPEAT_CYCLES - 1);
`endif

  btn_state_t stateNext;
  hold_cnt_t  cnt, cntNext;
  logic       shortNext, longNext;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      cnt        <= '0;
      shortPulse <= 1'b0;
      longPulse  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      shortPulse <= shortNext;
      longPulse  <= longNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    stateNext = state;
    cntNext   = cnt;
    shortNext = 1'b0;
    longNext  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          stateNext = HELD;
          cntNext   = '0;
        end
      end
      HELD: begin
        if (combo.lock) begin
          stateNext = LOCKED;
          cntNext   = '0;
        end else if (level) begin
          stateNext = IDLE;
          shortNext = (cnt < LONG_LAST);
          cntNext   = '0;
        end else if (cnt == LONG_TERM) begin
          stateNext = LONG;
          longNext  = !combo.active;
          cntNext   = '0;
        end else begin
          cntNext = satInc(cnt);
        end
      end
      LONG: begin
        if (combo.lock) begin
          stateNext = LOCKED;
          cntNext   = '0;
        end else if (level) begin
          stateNext = IDLE;
          cntNext   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == REPEAT_TERM) begin
          shortNext = !combo.active;
          cntNext   = '0;
        end else begin
          cntNext = satInc(cnt);
        end
`endif
      end
      LOCKED: begin
        if (combo.bothHigh) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: rtl/button_event_decoder.sv
// Decodes Trip/Mode button presses and Crank/Fork sensor edges into single-cycle strobes.
// Optional macro AUTO_REPEAT_EN (handled in button_fsm): auto-repeat of Short during a long press.
module button_event_decoder
  import cycle_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input logic                  clock,
  input logic                  nRst,
  button_event_decoder_if.slave bus
);

  localparam int TRIP  = 0;
  localparam int MODE  = 1;
  localparam int CRANK = 2;
  localparam int FORK  = 3;
  localparam hold_cnt_t COMBO_LAST = hold_cnt_t'(LONG_CYCLES - 1);

  logic [3:0]  level, prevLevel, fall;
  logic        armed;
  logic        bothLow, comboActive, comboDone;
  hold_cnt_t   comboCnt;
  combo_ctrl_t combo;
  btn_state_t  tripState, modeState;
  logic        bothLongReg, crankPulseReg, forkPulseReg;

  assign level = {bus.nFork_deglitch, bus.nCrank_deglitch, bus.nMode_deglitch, bus.nTrip_deglitch};

  // The first sample after reset only loads prevLevel, so a level already low is never an edge.
  assign fall = armed ? (prevLevel & ~level) : 4'b0000;

  assign bothLow     = !level[TRIP] && !level[MODE];
  assign comboActive = bothLow && isHolding(tripState) && isHolding(modeState);
  assign comboDone   = comboActive && (comboCnt == COMBO_LAST);
  assign combo       = '{active: comboActive, lock: comboDone, bothHigh: level[TRIP] && level[MODE]};

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      armed         <= 1'b0;
      prevLevel     <= 4'b1111;
      comboCnt      <= '0;
      bothLongReg   <= 1'b0;
      crankPulseReg <= 1'b0;
      forkPulseReg  <= 1'b0;
    end else begin
      armed         <= 1'b1;
      prevLevel     <= level;
      comboCnt      <= bothLow ? satInc(comboCnt) : '0;
      bothLongReg   <= comboDone;
      crankPulseReg <= fall[CRANK];
      forkPulseReg  <= fall[FORK];
    end
  end

  assign bus.bothLong   = bothLongReg;
  assign bus.crankPulse = crankPulseReg;
  assign bus.forkPulse  = forkPulseReg;

  button_fsm #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_tripFsm (
    .clock     (clock),
    .nRst      (nRst),
    .level     (level[TRIP]),
    .fall      (fall[TRIP]),
    .combo     (combo),
    .shortPulse(bus.tripShort),
    .longPulse (bus.tripLong),
    .state     (tripState)
  );

  button_fsm #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_modeFsm (
    .clock     (clock),
    .nRst      (nRst),
    .level     (level[MODE]),
    .fall      (fall[MODE]),
    .combo     (combo),
    .shortPulse(bus.modeShort),
    .longPulse (bus.modeLong),
    .state     (modeState)
  );

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: event-schedule model checked every cycle plus literal pins.
// Build with AUTO_REPEAT_EN defined to cover the auto-repeat variant.
module tb_button_event_decoder;

  localparam int L    = 64;
  localparam int R    = 16;
  localparam int MAXC = 2048;
  localparam int GAP  = 10;

  // Bit positions of the strobe vector.
  localparam int TS = 0, TL = 1, MS = 2, ML = 3, BL = 4, CP = 5, FP = 6;

  logic clock = 1'b0;
  logic nRst  = 1'b0;
  int   cyc   = 0;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clock(clock),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [6:0] act;
  assign act = {bus.forkPulse, bus.crankPulse, bus.bothLong, bus.modeLong,
                bus.modeShort, bus.tripLong, bus.tripShort};

  logic [6:0] expSched [MAXC] = '{default: '0};
  int checks = 0, failures = 0, shownFails = 0;
  int seen [7] = '{default: 0};
  int lastSeen [7] = '{default: -1};
  int snap [7];

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Every-cycle comparison of all strobes against the schedule, plus a pulse monitor.
  always @(negedge clock) begin
    if (cyc >= 1) begin
      checks++;
      if (cyc >= MAXC || act !== expSched[cyc]) begin
        failures++;
        if (shownFails < 20)
          $display("FAIL strobes cycle=%0d actual=%b required=%b", cyc, act,
                   (cyc < MAXC) ? expSched[cyc] : 7'b0);
        shownFails++;
      end
      for (int i = 0; i < 7; i++)
        if (act[i] === 1'b1) begin
          seen[i]++;
          lastSeen[i] = cyc;
        end
    end
  end

  task automatic mark(input int t, input int idx);
    if (t < MAXC) expSched[t][idx] = 1'b1;
  endtask

  // A press first sampled on edge p and released (first seen high) on edge p+d.
  task automatic schedButton(input bit isMode, input int p, input int d);
    int sIdx, lIdx;
    sIdx = isMode ? MS : TS;
    lIdx = isMode ? ML : TL;
    if (d <= L - 1) mark(p + d, sIdx);
    else begin
      mark(p + L - 1, lIdx);
`ifdef AUTO_REPEAT_EN
      for (int t = p + L - 1 + R; t < p + d; t += R) mark(t, sIdx);
`endif
    end
  endtask

  task automatic takeSnap();
    for (int i = 0; i < 7; i++) snap[i] = seen[i];
  endtask

  function automatic int delta(input int idx);
    return seen[idx] - snap[idx];
  endfunction

  task automatic pressButtons(input bit useTrip, input bit useMode, input int dT, input int dM,
                              output int p);
    int dMax;
    @(negedge clock);
    p = cyc + 1;
    if (useTrip && useMode && dT > L - 1 && dM > L - 1) mark(p + L - 1, BL);
    else begin
      if (useTrip) schedButton(1'b0, p, dT);
      if (useMode) schedButton(1'b1, p, dM);
    end
    if (useTrip) bus.nTrip_deglitch = 1'b0;
    if (useMode) bus.nMode_deglitch = 1'b0;
    dMax = (dT > dM) ? dT : dM;
    for (int k = 1; k <= dMax; k++) begin
      @(negedge clock);
      if (useTrip && k == dT) bus.nTrip_deglitch = 1'b1;
      if (useMode && k == dM) bus.nMode_deglitch = 1'b1;
    end
    repeat (GAP) @(negedge clock);
  endtask

  task automatic toggleSensor(input bit isFork, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      mark(cyc + 1, isFork ? FP : CP);
      if (isFork) bus.nFork_deglitch = 1'b0; else bus.nCrank_deglitch = 1'b0;
      repeat (2) @(negedge clock);
      if (isFork) bus.nFork_deglitch = 1'b1; else bus.nCrank_deglitch = 1'b1;
      repeat (3) @(negedge clock);
    end
    repeat (GAP) @(negedge clock);
  endtask

  initial begin
    int p;
    int total;
    bus.nTrip_deglitch  = 1'b1;
    bus.nMode_deglitch  = 1'b1;
    bus.nCrank_deglitch = 1'b1;
    bus.nFork_deglitch  = 1'b1;
    nRst = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_strobes", int'(act), 0);
    nRst = 1'b1;
    repeat (GAP) @(negedge clock);

    // Short press, well below the long threshold.
    takeSnap();
    pressButtons(1'b1, 1'b0, 20, 0, p);
    check("trip_short_count", delta(TS), 1);
    check("trip_short_latency", lastSeen[TS] - p, 20);
    check("trip_long_none", delta(TL), 0);

    // Longest hold that is still short: LONG_CYCLES-1 cycles.
    takeSnap();
    pressButtons(1'b1, 1'b0, L - 1, 0, p);
    check("trip_short_boundary", lastSeen[TS] - p, 63);
    check("trip_long_boundary_none", delta(TL), 0);

    // Shortest hold that is long: LONG_CYCLES cycles, release gives nothing.
    takeSnap();
    pressButtons(1'b0, 1'b1, 0, L, p);
    check("mode_long_boundary", lastSeen[ML] - p, 63);
    check("mode_short_boundary_none", delta(MS), 0);

    // Long hold: Long once at hold cycle LONG_CYCLES.
    takeSnap();
    pressButtons(1'b0, 1'b1, 0, 80, p);
    check("mode_long_count", delta(ML), 1);
    check("mode_long_cycle", lastSeen[ML] - p, 63);
`ifdef AUTO_REPEAT_EN
    check("mode_repeat_count", delta(MS), 1);
`else
    check("mode_short_none", delta(MS), 0);
`endif

    // Combo hold: bothLong once, no individual strobes.
    takeSnap();
    pressButtons(1'b1, 1'b1, 80, 80, p);
    check("both_long_count", delta(BL), 1);
    check("both_long_cycle", lastSeen[BL] - p, 63);
    check("combo_no_button_strobes", delta(TS) + delta(TL) + delta(MS) + delta(ML), 0);

    // Combo broken early: normal single-button rules apply.
    takeSnap();
    pressButtons(1'b1, 1'b1, 30, 80, p);
    check("combo_break_trip_short", lastSeen[TS] - p, 30);
    check("combo_break_mode_long", lastSeen[ML] - p, 63);
    check("combo_break_no_both", delta(BL), 0);

    // Quick Mode tap.
    takeSnap();
    pressButtons(1'b0, 1'b1, 0, 5, p);
    check("mode_short_count", delta(MS), 1);

    // Sensors.
    takeSnap();
    toggleSensor(1'b0, 5);
    check("crank_count", delta(CP), 5);
    check("fork_idle", delta(FP), 0);
    takeSnap();
    toggleSensor(1'b1, 2);
    check("fork_count", delta(FP), 2);
    check("crank_idle", delta(CP), 0);

    // Reset mid-press: the held button must stay silent until pressed again.
    takeSnap();
    @(negedge clock);
    bus.nTrip_deglitch = 1'b0;
    repeat (30) @(negedge clock);
    nRst = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_mid_press_strobes", int'(act), 0);
    nRst = 1'b1;
    repeat (L + 20) @(negedge clock);
    bus.nTrip_deglitch = 1'b1;
    repeat (GAP) @(negedge clock);
    total = 0;
    for (int i = 0; i < 7; i++) total += delta(i);
    check("reset_mid_press_silent", total, 0);
    takeSnap();
    pressButtons(1'b1, 1'b0, 50, 0, p);
    check("after_reset_short", lastSeen[TS] - p, 50);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat: Long at 64, repeats at 64+16 and 64+32.
    takeSnap();
    pressButtons(1'b1, 1'b0, 100, 0, p);
    check("repeat_long_cycle", lastSeen[TL] - p, 63);
    check("repeat_short_count", delta(TS), 2);
    check("repeat_last_cycle", lastSeen[TS] - p, 95);
`endif

    repeat (GAP) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 32768, hold time in clock cycles that turns a press into a long press.
REQ-002 Parameter REPEAT_CYCLES, default 8192, auto-repeat interval in clock cycles.
REQ-003 clock  input  1  system clock, rising edge.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 nTrip_deglitch, nMode_deglitch  input  1 each  clean button levels, low = pressed.
REQ-006 nCrank_deglitch, nFork_deglitch  input  1 each  clean sensor levels, low = magnet present.
REQ-007 tripShort, tripLong, modeShort, modeLong  output  1 each  single-cycle event strobes.
REQ-008 bothLong  output  1  single-cycle strobe for a combined Trip+Mode long press.
REQ-009 crankPulse, forkPulse  output  1 each  single-cycle strobe on each falling edge of the sensor level.

Function
REQ-010 Each input has a previous-level register; a falling edge is prev=1 and current=0.
REQ-011 crankPulse and forkPulse assert the cycle after a detected falling edge (1-cycle latency), for exactly one cycle.
REQ-012 Each button has an FSM with states IDLE, HELD, LONG, LOCKED, plus a 16-bit hold counter.
REQ-013 IDLE to HELD on falling edge, counter cleared to 0.
REQ-014 In HELD, the counter increments each cycle while the level is low.
REQ-015 HELD to IDLE on release with counter < LONG_CYCLES-1, emitting the Short strobe in the cycle after release.
REQ-016 HELD to LONG when counter reaches LONG_CYCLES-1, emitting the Long strobe once and clearing the counter.
REQ-017 LONG to IDLE on release, with no strobe.
REQ-018 The counter saturates at 16'hFFFF and never wraps.
REQ-019 Combo: both buttons low, and both FSMs in HELD or LONG, for LONG_CYCLES consecutive cycles -> bothLong pulses once, and both FSMs enter LOCKED.
REQ-020 A combo counter, separate from the hold counters, tracks the simultaneous hold; it clears whenever either button is high.
REQ-021 While the combo is in progress, individual Long strobes are suppressed; a release before combo completion follows the normal single-button rules.
REQ-022 LOCKED suppresses all strobes; it returns to IDLE only when both buttons are high.
REQ-023 If combo completion and an individual HELD-to-LONG transition fall in the same cycle, bothLong wins and no individual Long is emitted.
REQ-024 At most one strobe per button asserts per cycle; outputs are registered.

Reset
REQ-025 On nRst low, all strobes = 0, all FSMs = IDLE, all counters = 0, all previous-level registers = 1.
REQ-026 Reset mid-press: after release of nRst, a button still held low generates no event until it is released and pressed again, since prev=1 requires a fresh falling edge.

Configuration
REQ-027 Macro AUTO_REPEAT_EN:
- Defined: in LONG, the Short strobe re-asserts every REPEAT_CYCLES cycles while the button is held, the first one REPEAT_CYCLES after the Long strobe. Repeat is inhibited in LOCKED.
- Undefined: no repeat logic is built, and LONG emits nothing further.

Structure
REQ-028 Package cycle_pkg holds the state enum btn_state_t (IDLE, HELD, LONG, LOCKED) and the default constants LONG_CYCLES_DEF and REPEAT_CYCLES_DEF.
REQ-029 One sub-module, button_fsm, is instantiated twice (Trip, Mode): it takes the level and a combo-lock input and provides the short, long and state outputs.

Verification
REQ-030 Trip low for 100 cycles then high -> tripShort single pulse 1 cycle after release; tripLong stays 0.
REQ-031 Mode low for 40000 cycles -> modeLong pulses at cycle 32768 of the hold; no modeShort on release (AUTO_REPEAT_EN undefined).
REQ-032 Both low together for 40000 cycles -> bothLong once at cycle 32768; no Trip/Mode strobes until both are released; no strobes on release.
REQ-033 nCrank_deglitch toggled 5 times -> exactly 5 crankPulse strobes, each 1 cycle wide; forkPulse remains 0.
REQ-034 nRst asserted at hold cycle 20000 and released while Trip is still low -> no strobe after the 32768-cycle mark; release and re-press for 50 cycles -> tripShort.
REQ-035 With AUTO_REPEAT_EN defined, Trip held 50000 cycles -> tripLong at 32768, then tripShort at 40960 and 49152.
